// File: rtl/dcache_if.sv
// dcache_if: CPU load/store and block-memory signals of the direct-mapped data cache
interface dcache_if #(
  parameter int ADDR_W   = 8,
  parameter int WORD_W   = 32,
  parameter int OFFSET_W = 2
);
  localparam int BLOCK_W = WORD_W << OFFSET_W;
  logic                       read;
  logic                       write;
  logic [ADDR_W-1:0]          address;
  logic [WORD_W-1:0]          writedata;
  logic [WORD_W-1:0]          readdata;
  logic                       busywait;
  logic                       mem_read;
  logic                       mem_write;
  logic [ADDR_W-OFFSET_W-1:0] mem_address;
  logic [BLOCK_W-1:0]         mem_writedata;
  logic [BLOCK_W-1:0]         mem_readdata;
  logic                       mem_busywait;
  modport master (
    output read, write, address, writedata, mem_readdata, mem_busywait,
    input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );
  modport slave (
    input  read, write, address, writedata, mem_readdata, mem_busywait,
    output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/dcache_dm.sv
// dcache_dm: direct-mapped write-back write-allocate data cache with miss-handling FSM
module dcache_dm #(
  parameter int ADDR_W   = 8,
  parameter int WORD_W   = 32,
  parameter int INDEX_W  = 3,
  parameter int OFFSET_W = 2
) (
  input logic     clock,
  input logic     reset,
  dcache_if.slave bus
);
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;
  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, ALLOCATE} state_t;
  state_t                         state_q, state_d;
  logic [LINES-1:0]               valid_q, valid_d, dirty_q, dirty_d;
  logic [TAG_W-1:0]               tag_q [LINES];
  logic [WORDS-1:0][WORD_W-1:0]   data_q [LINES];
  logic [WORDS-1:0][WORD_W-1:0]   fill_q;
  logic [TAG_W-1:0]               tag;
  logic [INDEX_W-1:0]             idx;
  logic [OFFSET_W-1:0]            off;
  logic                           hit, req, write_hit, alloc;
  assign tag       = bus.address[ADDR_W-1 -: TAG_W];
  assign idx       = bus.address[OFFSET_W +: INDEX_W];
  assign off       = bus.address[OFFSET_W-1:0];
  assign hit       = valid_q[idx] && (tag_q[idx] == tag);
  assign req       = bus.read | bus.write;
  assign write_hit = (state_q == IDLE) && bus.write && hit;
  assign alloc     = (state_q == ALLOCATE);
  // Stall is forced low while reset is held so a pending request cannot freeze the CPU
  assign bus.busywait = !reset && ((state_q != IDLE) || (req && !hit));
  assign bus.readdata = (state_q == IDLE && bus.read && !bus.write && hit) ? data_q[idx][off] : '0;
  // Miss sequencing and memory handshake; write-back always precedes the fetch of a dirty line
  always_comb begin
    state_d           = state_q;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_address   = '0;
    bus.mem_writedata = '0;
    case (state_q)
      IDLE:      if (req && !hit) state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : FETCH;
      WRITEBACK: begin
        bus.mem_write     = 1'b1;
        bus.mem_address   = {tag_q[idx], idx};
        bus.mem_writedata = data_q[idx];
        state_d           = bus.mem_busywait ? WRITEBACK : FETCH;
      end
      FETCH: begin
        bus.mem_read    = 1'b1;
        bus.mem_address = {tag, idx};
        state_d         = bus.mem_busywait ? FETCH : ALLOCATE;
      end
      default:   state_d = IDLE;
    endcase
  end
  // Line status: allocation installs a clean valid line, a store hit marks it dirty
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (alloc) begin
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
    end else if (write_hit) dirty_d[idx] = 1'b1;
  end
  // State and status bits clear asynchronously so an interrupted miss leaves nothing behind
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  // Block storage: capture the fetched block, install it on allocate, merge store words on hit
  always_ff @(posedge clock) begin
    if (state_q == FETCH && !bus.mem_busywait) fill_q <= bus.mem_readdata;
    if (alloc) begin
      data_q[idx] <= fill_q;
      tag_q[idx]  <= tag;
    end else if (write_hit) data_q[idx][off] <= bus.writedata;
  end
endmodule

// File: tb/tb_dcache_dm.sv
// tb_dcache_dm: randomized and directed checks of dcache_dm against a line-level cache model
module tb_dcache_dm;
  localparam int ADDR_W = 8, WORD_W = 32, INDEX_W = 3, OFFSET_W = 2;
  localparam int TAG_W = 3, BLOCK_W = 128, LINES = 8, BLOCKS = 64;
  logic clock = 1'b0, reset = 1'b0;
  dcache_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .OFFSET_W(OFFSET_W)) bus ();
  dcache_dm #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W))
    dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;

  int passed = 0, total = 0;
  int mem_lat = 5, cnt = 0;
  logic               mbw = 1'b1;
  logic [BLOCK_W-1:0] mrd = '0;
  logic [BLOCK_W-1:0] mem [BLOCKS];
  logic [BLOCK_W-1:0] ref_mem [BLOCKS];
  bit                 ref_valid [LINES];
  bit                 ref_dirty [LINES];
  logic [TAG_W-1:0]   ref_tag [LINES];
  logic [BLOCK_W-1:0] ref_data [LINES];
  logic [WORD_W-1:0]  last_rd;
  assign bus.mem_busywait = mbw;
  assign bus.mem_readdata = mrd;

  // Block memory: busy for mem_lat cycles per request, then one low cycle marks completion
  always @(negedge clock) begin
    if (!mbw) begin
      mbw = 1'b1;
      cnt = 0;
    end
    if (bus.mem_read || bus.mem_write) begin
      cnt++;
      if (cnt == mem_lat) begin
        mbw = 1'b0;
        if (bus.mem_write) mem[bus.mem_address] = bus.mem_writedata;
        else mrd = mem[bus.mem_address];
      end
    end else cnt = 0;
  end

  task automatic clear_model();
    for (int i = 0; i < LINES; i++) begin
      ref_valid[i] = 0;
      ref_dirty[i] = 0;
    end
  endtask

  task automatic access(input bit rd, input bit wr, input logic [7:0] a, input logic [31:0] wd);
    logic [2:0]   t, i;
    logic [1:0]   o;
    bit           hit, exp_wb, saw_wb, saw_f, overlap;
    logic [5:0]   wb_a, wb_obs_a, f_obs_a;
    logic [127:0] wb_d, wb_obs_d;
    logic [31:0]  exp_rd;
    int           exp_stall, stall;
    t = a[7:5];
    i = a[4:2];
    o = a[1:0];
    hit = ref_valid[i] && ref_tag[i] == t;
    exp_wb = !hit && ref_valid[i] && ref_dirty[i];
    exp_stall = hit ? 0 : (exp_wb ? 2 * mem_lat + 2 : mem_lat + 2);
    wb_a = {ref_tag[i], i};
    wb_d = ref_data[i];
    if (exp_wb) ref_mem[wb_a] = wb_d;
    if (!hit) begin
      ref_data[i] = ref_mem[{t, i}];
      ref_tag[i] = t;
      ref_valid[i] = 1;
      ref_dirty[i] = 0;
    end
    exp_rd = (rd && !wr) ? ref_data[i][o*32 +: 32] : 32'h0;
    if (wr) begin
      ref_data[i][o*32 +: 32] = wd;
      ref_dirty[i] = 1;
    end
    @(negedge clock);
    bus.read = rd;
    bus.write = wr;
    bus.address = a;
    bus.writedata = wd;
    #1;
    stall = 0;
    saw_wb = 0;
    saw_f = 0;
    overlap = 0;
    wb_obs_a = 'x;
    wb_obs_d = 'x;
    f_obs_a = 'x;
    while (bus.busywait === 1'b1 && stall < 300) begin
      if (bus.mem_write && bus.mem_read) overlap = 1;
      if (bus.mem_write && !saw_wb) begin
        saw_wb = 1;
        wb_obs_a = bus.mem_address;
        wb_obs_d = bus.mem_writedata;
      end
      if (bus.mem_read && !saw_f) begin
        saw_f = 1;
        f_obs_a = bus.mem_address;
      end
      stall++;
      @(negedge clock);
      #1;
    end
    total++;
    if (stall !== exp_stall) $display("FAIL stall @%h: got %0d cycles expected %0d", a, stall, exp_stall);
    else passed++;
    total++;
    if (saw_wb !== exp_wb) $display("FAIL writeback_seen @%h: got %0d expected %0d", a, saw_wb, exp_wb);
    else passed++;
    if (exp_wb) begin
      total++;
      if (wb_obs_a !== wb_a || wb_obs_d !== wb_d)
        $display("FAIL writeback_block @%h: got %h/%h expected %h/%h", a, wb_obs_a, wb_obs_d, wb_a, wb_d);
      else passed++;
    end
    total++;
    if (hit ? saw_f : (f_obs_a !== {t, i}))
      $display("FAIL fetch @%h: got seen=%0d addr=%h expected seen=%0d addr=%h", a, saw_f, f_obs_a, !hit, {t, i});
    else passed++;
    total++;
    if (overlap) $display("FAIL mem_overlap @%h: got mem_read&mem_write=1 expected 0", a);
    else passed++;
    total++;
    if (bus.readdata !== exp_rd) $display("FAIL readdata @%h: got %h expected %h", a, bus.readdata, exp_rd);
    else passed++;
    last_rd = bus.readdata;
  endtask

  task automatic go_idle();
    @(negedge clock);
    bus.read = 0;
    bus.write = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    #1;
    total++;
    if ({bus.busywait, bus.mem_read, bus.mem_write} !== 3'b000)
      $display("FAIL reset_ctrl: got %b expected 000", {bus.busywait, bus.mem_read, bus.mem_write});
    else passed++;
    total++;
    if (bus.readdata !== 32'h0) $display("FAIL reset_readdata: got %h expected 0", bus.readdata);
    else passed++;
    total++;
    if (bus.mem_address !== 6'h0 || bus.mem_writedata !== 128'h0)
      $display("FAIL reset_mem_bus: got %h/%h expected 0/0", bus.mem_address, bus.mem_writedata);
    else passed++;
    @(negedge clock);
    reset = 0;
    clear_model();
  endtask

  task automatic test_directed();
    mem_lat = 5;
    mem[9] = 128'h00004444_00003333_00002222_00001111;
    ref_mem[9] = mem[9];
    access(1, 0, 8'h25, 0);
    total++;
    if (last_rd !== 32'h2222) $display("FAIL first_fill_read: got %h expected 00002222", last_rd);
    else passed++;
    access(0, 1, 8'h24, 32'hDEADBEEF);
    access(1, 0, 8'h24, 0);
    total++;
    if (last_rd !== 32'hDEADBEEF) $display("FAIL write_hit_read: got %h expected deadbeef", last_rd);
    else passed++;
    access(1, 0, 8'h44, 0);
    access(1, 0, 8'h64, 0);
    go_idle();
  endtask

  task automatic test_reset_mid_miss();
    int n = 0;
    @(negedge clock);
    bus.read = 1;
    bus.write = 0;
    bus.address = 8'h44;
    #1;
    while (bus.mem_read !== 1'b1 && n < 50) begin
      n++;
      @(negedge clock);
      #1;
    end
    total++;
    if (bus.mem_read !== 1'b1) $display("FAIL fetch_start: got mem_read=%b expected 1", bus.mem_read);
    else passed++;
    #2 reset = 1;
    #1;
    total++;
    if ({bus.mem_read, bus.mem_write, bus.busywait} !== 3'b000)
      $display("FAIL reset_mid_fetch: got %b expected 000", {bus.mem_read, bus.mem_write, bus.busywait});
    else passed++;
    @(negedge clock);
    bus.read = 0;
    reset = 0;
    clear_model();
    access(1, 0, 8'h44, 0);
    go_idle();
  endtask

  task automatic test_rw_simul();
    access(1, 1, 8'h45, 32'hCAFEF00D);
    access(1, 0, 8'h45, 0);
    total++;
    if (last_rd !== 32'hCAFEF00D) $display("FAIL rw_write_taken: got %h expected cafef00d", last_rd);
    else passed++;
    go_idle();
  endtask

  task automatic test_index_wrap();
    mem_lat = 2;
    access(1, 0, 8'hFC, 0);
    access(1, 0, 8'h00, 0);
    access(0, 1, 8'hFD, 32'h12345678);
    access(1, 0, 8'h01, 0);
    access(1, 0, 8'hFD, 0);
    access(1, 0, 8'h1C, 0);
    go_idle();
  endtask

  task automatic test_random();
    repeat (300) begin
      int op;
      logic [7:0] a;
      mem_lat = $urandom_range(1, 4);
      op = $urandom_range(0, 3);
      a = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      access(op != 2, op >= 2, a, $urandom);
    end
    go_idle();
  endtask

  initial begin
    bus.read = 0;
    bus.write = 0;
    bus.address = '0;
    bus.writedata = '0;
    for (int b = 0; b < BLOCKS; b++) begin
      mem[b] = {$urandom, $urandom, $urandom, $urandom};
      ref_mem[b] = mem[b];
    end
    test_reset();
    test_directed();
    test_reset_mid_miss();
    test_rw_simul();
    test_index_wrap();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
